// File: rtl/fir_xifu_issue_queue_pkg.sv
// Shared types, opcode constants and instruction field helpers for the FIR XIFU.
package fir_xifu_pkg;

  localparam logic [6:0] INSTR_OPCODE     = 7'h0B;
  localparam logic [2:0] XFIRLW_FUNCT3    = 3'd0;
  localparam logic [2:0] XFIRSW_FUNCT3    = 3'd1;
  localparam logic [2:0] XFIRDOTP_FUNCT3  = 3'd2;

  // Upper bound for the X-interface id width carried through the queue.
  localparam int ID_MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    XFIRLW   = 2'd1,
    XFIRSW   = 2'd2,
    XFIRDOTP = 2'd3
  } fir_xifu_instr_t;

  typedef struct packed {
    fir_xifu_instr_t         instr;
    logic [ID_MAX_WIDTH-1:0] id;
    logic [31:0]             base;
    logic [31:0]             offset;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
  } fir_xifu_id2ex_t;

  typedef struct packed {
    fir_xifu_id2ex_t payload;
    logic            committed;
    logic            killed;
  } fir_xifu_qentry_t;

  function automatic logic [6:0] xifu_get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] xifu_get_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [4:0] xifu_get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] xifu_get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [4:0] xifu_get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [31:0] xifu_get_immediate_I(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] xifu_get_immediate_S(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

endpackage

// File: rtl/fir_xifu_issue_queue_if.sv
// Issue, commit, EX-dispatch and writeback signals of the XIFU issue stage.
interface fir_xifu_issue_queue_if
  import fir_xifu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_XREGS = 8,
  parameter int ID_WIDTH  = 4
);
  logic                         issue_valid_i;
  logic                         issue_ready_o;
  logic [31:0]                  issue_instr_i;
  logic [ID_WIDTH-1:0]          issue_id_i;
  logic [1:0][31:0]             issue_rs_i;
  logic [1:0]                   issue_rs_valid_i;
  logic                         issue_accept_o;
  logic                         issue_writeback_o;
  logic                         issue_loadstore_o;
  logic                         commit_valid_i;
  logic [ID_WIDTH-1:0]          commit_id_i;
  logic                         commit_kill_i;
  logic                         ex_valid_o;
  logic                         ex_ready_i;
  fir_xifu_id2ex_t              ex_entry_o;
  logic                         wb_valid_i;
  logic [$clog2(NUM_XREGS)-1:0] wb_rd_i;
  logic [$clog2(DEPTH):0]       count_o;

  // Issue-stage side.
  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  ex_ready_i, wb_valid_i, wb_rd_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o, issue_loadstore_o,
    output ex_valid_o, ex_entry_o, count_o
  );

  // Core / EX side.
  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output ex_ready_i, wb_valid_i, wb_rd_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o, issue_loadstore_o,
    input  ex_valid_o, ex_entry_o, count_o
  );

endinterface

// File: rtl/fir_xifu_issue_queue_scoreboard.sv
// Busy-bit scoreboard over the internal FIR register file.
module fir_xifu_scoreboard #(
  parameter  int NUM_XREGS = 8,
  localparam int XW        = $clog2(NUM_XREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_set_en,
  input  logic [XW-1:0] i_set_idx,
  input  logic          i_clr0_en,
  input  logic [XW-1:0] i_clr0_idx,
  input  logic          i_clr1_en,
  input  logic [XW-1:0] i_clr1_idx,
  input  logic [XW-1:0] i_look_a_idx,
  input  logic [XW-1:0] i_look_b_idx,
  input  logic [XW-1:0] i_look_c_idx,
  output logic          o_busy_a,
  output logic          o_busy_b,
  output logic          o_busy_c
);

  logic [NUM_XREGS-1:0] r_busy;
  logic [NUM_XREGS-1:0] w_busy_nxt;

  // Clears first, then the set, so a set to the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr0_en) w_busy_nxt[i_clr0_idx] = 1'b0;
    if (i_clr1_en) w_busy_nxt[i_clr1_idx] = 1'b0;
    if (i_set_en)  w_busy_nxt[i_set_idx]  = 1'b1;
  end

  // Busy-bit register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign o_busy_a = r_busy[i_look_a_idx];
  assign o_busy_b = r_busy[i_look_b_idx];
  assign o_busy_c = r_busy[i_look_c_idx];

endmodule

// File: rtl/fir_xifu_issue_queue.sv
// FIR XIFU issue stage: decode, in-order commit-gated queue and xreg hazard stall.
module fir_xifu_issue_queue
  import fir_xifu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_XREGS = 8,
  parameter int ID_WIDTH  = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  fir_xifu_issue_queue_if.slave bus
);

  localparam int XW = $clog2(NUM_XREGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fir_xifu_instr_t  w_type;
  logic [4:0]       w_rs1, w_rs2, w_rd;
  logic [31:0]      w_offset;
  logic             w_accept, w_loadstore;
  logic             w_uses_rs1, w_uses_rs2, w_writes_rd, w_needs_base;
  logic             w_busy_rs1, w_busy_rs2, w_busy_rd;
  logic             w_full, w_ready, w_push, w_pop, w_kill_pop, w_ex_valid;
  logic             w_commit_new, w_head_clr;
  fir_xifu_id2ex_t  w_new;
  fir_xifu_qentry_t w_head;
  logic             w_unused;

  fir_xifu_qentry_t r_q [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;

  // Decode the offered instruction into its type, operands and offset.
  always_comb begin
    w_type = INVALID;
    if (xifu_get_opcode(bus.issue_instr_i) == INSTR_OPCODE) begin
      unique case (xifu_get_funct3(bus.issue_instr_i))
        XFIRLW_FUNCT3:   w_type = XFIRLW;
        XFIRSW_FUNCT3:   w_type = XFIRSW;
        XFIRDOTP_FUNCT3: w_type = XFIRDOTP;
        default:         w_type = INVALID;
      endcase
    end
    w_rs1        = xifu_get_rs1(bus.issue_instr_i);
    w_rs2        = xifu_get_rs2(bus.issue_instr_i);
    w_rd         = xifu_get_rd(bus.issue_instr_i);
    w_accept     = (w_type != INVALID);
    w_loadstore  = (w_type == XFIRLW) || (w_type == XFIRSW);
    w_needs_base = w_loadstore;
    w_uses_rs1   = (w_type == XFIRDOTP);
    w_uses_rs2   = (w_type == XFIRSW) || (w_type == XFIRDOTP);
    w_writes_rd  = (w_type == XFIRLW) || (w_type == XFIRDOTP);
    w_offset     = '0;
    if (w_type == XFIRLW)      w_offset = xifu_get_immediate_I(bus.issue_instr_i);
    else if (w_type == XFIRSW) w_offset = xifu_get_immediate_S(bus.issue_instr_i);
  end

  assign w_full  = (r_count == CW'(DEPTH));
  // Unrecognised instructions are rejected immediately rather than stalled.
  assign w_ready = !w_accept ||
                   (!w_full &&
                    (!w_needs_base || bus.issue_rs_valid_i[0]) &&
                    !(w_uses_rs1 && w_busy_rs1) &&
                    !(w_uses_rs2 && w_busy_rs2) &&
                    !(w_writes_rd && w_busy_rd));
  assign w_push  = bus.issue_valid_i && w_ready && w_accept;

  assign w_new.instr  = w_type;
  assign w_new.id     = ID_MAX_WIDTH'(bus.issue_id_i);
  assign w_new.base   = bus.issue_rs_i[0];
  assign w_new.offset = w_offset;
  assign w_new.rs1    = w_rs1;
  assign w_new.rs2    = w_rs2;
  assign w_new.rd     = w_rd;

  assign w_commit_new = bus.commit_valid_i && (bus.commit_id_i == bus.issue_id_i);

  assign w_head     = r_q[r_head];
  assign w_ex_valid = r_vld[r_head] && w_head.committed && !w_head.killed;
  assign w_kill_pop = r_vld[r_head] && w_head.killed;
  assign w_pop      = (w_ex_valid && bus.ex_ready_i) || w_kill_pop;
  assign w_head_clr = w_kill_pop &&
                      ((w_head.payload.instr == XFIRLW) || (w_head.payload.instr == XFIRDOTP));

  fir_xifu_scoreboard #(.NUM_XREGS(NUM_XREGS)) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_set_en     (w_push && w_writes_rd),
    .i_set_idx    (w_rd[XW-1:0]),
    .i_clr0_en    (bus.wb_valid_i),
    .i_clr0_idx   (bus.wb_rd_i),
    .i_clr1_en    (w_head_clr),
    .i_clr1_idx   (w_head.payload.rd[XW-1:0]),
    .i_look_a_idx (w_rs1[XW-1:0]),
    .i_look_b_idx (w_rs2[XW-1:0]),
    .i_look_c_idx (w_rd[XW-1:0]),
    .o_busy_a     (w_busy_rs1),
    .o_busy_b     (w_busy_rs2),
    .o_busy_c     (w_busy_rd)
  );

  // Queue storage: commit/kill marking, head pop and tail push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && bus.commit_valid_i &&
            (r_q[i].payload.id[ID_WIDTH-1:0] == bus.commit_id_i)) begin
          if (bus.commit_kill_i) r_q[i].killed    <= 1'b1;
          else                   r_q[i].committed <= 1'b1;
        end
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push) begin
        r_q[r_tail].payload   <= w_new;
        r_q[r_tail].committed <= w_commit_new && !bus.commit_kill_i;
        r_q[r_tail].killed    <= w_commit_new && bus.commit_kill_i;
        r_vld[r_tail]         <= 1'b1;
        r_tail                <= r_tail + PW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign bus.issue_ready_o     = w_ready;
  assign bus.issue_accept_o    = w_accept;
  assign bus.issue_loadstore_o = w_loadstore;
  assign bus.issue_writeback_o = 1'b0;
  assign bus.ex_valid_o        = w_ex_valid;
  assign bus.ex_entry_o        = w_head.payload;
  assign bus.count_o           = r_count;

  // The second GPR operand is not used by any FIR instruction.
  assign w_unused = ^{bus.issue_rs_i[1], bus.issue_rs_valid_i[1]};

endmodule

// File: tb/tb_fir_xifu_issue_queue.sv
// Directed self-checking bench for the FIR XIFU issue queue.
module tb_fir_xifu_issue_queue;
  import fir_xifu_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;
  fir_xifu_id2ex_t e;

  fir_xifu_issue_queue_if #(.DEPTH(4), .NUM_XREGS(8), .ID_WIDTH(4)) bus ();

  fir_xifu_issue_queue #(.DEPTH(4), .NUM_XREGS(8), .ID_WIDTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, XFIRLW_FUNCT3, rd, INSTR_OPCODE};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, XFIRSW_FUNCT3, imm[4:0], INSTR_OPCODE};
  endfunction

  function automatic logic [31:0] enc_dotp(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, XFIRDOTP_FUNCT3, rd, INSTR_OPCODE};
  endfunction

  task automatic commit(input logic v, input logic [3:0] id, input logic kill);
    bus.commit_valid_i = v;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.issue_valid_i    = 1'b0;
    bus.issue_instr_i    = '0;
    bus.issue_id_i       = '0;
    bus.issue_rs_i       = '0;
    bus.issue_rs_valid_i = '0;
    bus.ex_ready_i       = 1'b0;
    bus.wb_valid_i       = 1'b0;
    bus.wb_rd_i          = '0;
    commit(1'b0, 4'd0, 1'b0);
    #1;
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_exv", 64'(bus.ex_valid_o), 64'd0);
    step(); step();
    rst_ni = 1'b1;

    // LW rd=3 imm=-4 base 0x1000, issued and committed together
    bus.issue_valid_i    = 1'b1;
    bus.issue_instr_i    = enc_lw(5'd3, 5'd1, 12'hFFC);
    bus.issue_id_i       = 4'd0;
    bus.issue_rs_i[0]    = 32'h1000;
    bus.issue_rs_valid_i = 2'b01;
    commit(1'b1, 4'd0, 1'b0);
    #1;
    check("lw_accept", 64'(bus.issue_accept_o), 64'd1);
    check("lw_ls", 64'(bus.issue_loadstore_o), 64'd1);
    check("lw_wb", 64'(bus.issue_writeback_o), 64'd0);
    check("lw_ready", 64'(bus.issue_ready_o), 64'd1);
    step();
    bus.issue_valid_i = 1'b0;
    commit(1'b0, 4'd0, 1'b0);
    #1;
    e = bus.ex_entry_o;
    check("lw_exv", 64'(bus.ex_valid_o), 64'd1);
    check("lw_base", 64'(e.base), 64'h1000);
    check("lw_off", 64'(e.offset), 64'hFFFF_FFFC);
    check("lw_rd", 64'(e.rd), 64'd3);
    check("lw_instr", 64'(e.instr), 64'(XFIRLW));
    check("lw_count", 64'(bus.count_o), 64'd1);
    step();
    e = bus.ex_entry_o;
    check("lw_hold_v", 64'(bus.ex_valid_o), 64'd1);
    check("lw_hold_base", 64'(e.base), 64'h1000);
    bus.ex_ready_i = 1'b1;
    step();
    bus.ex_ready_i = 1'b0;
    #1;
    check("lw_pop_count", 64'(bus.count_o), 64'd0);
    check("lw_pop_exv", 64'(bus.ex_valid_o), 64'd0);

    // DOTP rd=5 reading busy xreg 3
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = enc_dotp(5'd5, 5'd3, 5'd4);
    bus.issue_id_i    = 4'd1;
    #1;
    check("raw_stall0", 64'(bus.issue_ready_o), 64'd0);
    step();
    check("raw_stall1", 64'(bus.issue_ready_o), 64'd0);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd3;
    #1;
    check("raw_wb_cycle", 64'(bus.issue_ready_o), 64'd0);
    step();
    bus.wb_valid_i = 1'b0;
    #1;
    check("raw_release", 64'(bus.issue_ready_o), 64'd1);
    check("dotp_ls", 64'(bus.issue_loadstore_o), 64'd0);
    check("dotp_accept", 64'(bus.issue_accept_o), 64'd1);
    step();
    bus.issue_valid_i = 1'b0;
    #1;
    check("dotp_count", 64'(bus.count_o), 64'd1);
    check("dotp_uncommitted", 64'(bus.ex_valid_o), 64'd0);
    // WAW probe on rd=5 while committing the DOTP
    bus.issue_instr_i = enc_lw(5'd5, 5'd1, 12'd0);
    commit(1'b1, 4'd1, 1'b0);
    bus.ex_ready_i = 1'b1;
    #1;
    check("waw_stall", 64'(bus.issue_ready_o), 64'd0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    #1;
    e = bus.ex_entry_o;
    check("dotp_exv", 64'(bus.ex_valid_o), 64'd1);
    check("dotp_id", 64'(e.id), 64'd1);
    step();
    check("dotp_pop", 64'(bus.count_o), 64'd0);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd5;
    step();
    bus.wb_valid_i = 1'b0;

    // Set and clear on xreg 6 in one cycle: set wins
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = enc_lw(5'd6, 5'd1, 12'd0);
    bus.issue_id_i    = 4'd2;
    commit(1'b1, 4'd2, 1'b0);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd6;
    #1;
    check("sw6_ready", 64'(bus.issue_ready_o), 64'd1);
    step();
    bus.issue_valid_i = 1'b0;
    bus.wb_valid_i    = 1'b0;
    commit(1'b0, 4'd0, 1'b0);
    #1;
    check("set_wins_exv", 64'(bus.ex_valid_o), 64'd1);
    check("set_wins", 64'(bus.issue_ready_o), 64'd0);
    step();
    check("set_wins_pop", 64'(bus.count_o), 64'd0);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd6;
    step();
    bus.wb_valid_i = 1'b0;
    bus.ex_ready_i = 1'b0;

    // Fill with four SW, then out-of-order commits
    bus.issue_instr_i    = enc_sw(5'd7, 5'd2, 12'd8);
    bus.issue_rs_i[0]    = 32'h2000;
    bus.issue_rs_valid_i = 2'b00;
    #1;
    check("sw_rs0_invalid", 64'(bus.issue_ready_o), 64'd0);
    bus.issue_rs_valid_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid_i = 1'b1;
      bus.issue_id_i    = 4'(i);
      #1;
      check($sformatf("fill_ready%0d", i), 64'(bus.issue_ready_o), 64'd1);
      step();
    end
    bus.issue_valid_i = 1'b0;
    #1;
    check("full_count", 64'(bus.count_o), 64'd4);
    check("full_stall", 64'(bus.issue_ready_o), 64'd0);
    bus.ex_ready_i = 1'b1;
    commit(1'b1, 4'd2, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    #1;
    check("wait_head0", 64'(bus.ex_valid_o), 64'd0);
    check("wait_count", 64'(bus.count_o), 64'd4);
    commit(1'b1, 4'd0, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    #1;
    e = bus.ex_entry_o;
    check("head0_exv", 64'(bus.ex_valid_o), 64'd1);
    check("head0_id", 64'(e.id), 64'd0);
    check("head0_off", 64'(e.offset), 64'd8);
    check("head0_rs2", 64'(e.rs2), 64'd7);
    step();
    check("head1_wait", 64'(bus.ex_valid_o), 64'd0);
    check("head1_count", 64'(bus.count_o), 64'd3);
    commit(1'b1, 4'd1, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    #1;
    e = bus.ex_entry_o;
    check("head1_exv", 64'(bus.ex_valid_o), 64'd1);
    check("head1_id", 64'(e.id), 64'd1);
    step();
    e = bus.ex_entry_o;
    check("head2_exv", 64'(bus.ex_valid_o), 64'd1);
    check("head2_id", 64'(e.id), 64'd2);
    check("head2_count", 64'(bus.count_o), 64'd2);
    step();
    check("head3_wait", 64'(bus.ex_valid_o), 64'd0);
    check("head3_count", 64'(bus.count_o), 64'd1);
    bus.ex_ready_i = 1'b0;

    // Kill handling: queue holds id3 (SW), add id4 (LW rd=2), id5 (SW, committed)
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = enc_lw(5'd2, 5'd1, 12'd0);
    bus.issue_id_i    = 4'd4;
    step();
    bus.issue_instr_i = enc_sw(5'd7, 5'd2, 12'd0);
    bus.issue_id_i    = 4'd5;
    commit(1'b1, 4'd5, 1'b0);
    step();
    bus.issue_valid_i = 1'b0;
    commit(1'b1, 4'd3, 1'b1);
    #1;
    check("kill_count3", 64'(bus.count_o), 64'd3);
    step();
    commit(1'b1, 4'd4, 1'b1);
    bus.issue_instr_i = enc_lw(5'd2, 5'd1, 12'd0);
    #1;
    check("kill_head_exv", 64'(bus.ex_valid_o), 64'd0);
    check("kill_busy2", 64'(bus.issue_ready_o), 64'd0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    #1;
    check("kill_pop3", 64'(bus.count_o), 64'd2);
    check("kill_lw_exv", 64'(bus.ex_valid_o), 64'd0);
    step();
    e = bus.ex_entry_o;
    check("kill_pop4", 64'(bus.count_o), 64'd1);
    check("after_kill_exv", 64'(bus.ex_valid_o), 64'd1);
    check("after_kill_id", 64'(e.id), 64'd5);
    check("busy2_released", 64'(bus.issue_ready_o), 64'd1);
    bus.ex_ready_i = 1'b1;
    step();
    check("kill_drain", 64'(bus.count_o), 64'd0);
    bus.ex_ready_i = 1'b0;

    // Foreign opcode and unknown funct3
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = 32'h0020_80B3;
    bus.issue_id_i    = 4'd6;
    #1;
    check("foreign_accept", 64'(bus.issue_accept_o), 64'd0);
    check("foreign_ls", 64'(bus.issue_loadstore_o), 64'd0);
    check("foreign_ready", 64'(bus.issue_ready_o), 64'd1);
    step();
    check("foreign_count", 64'(bus.count_o), 64'd0);
    bus.issue_instr_i = {17'd0, 3'b011, 5'd1, INSTR_OPCODE};
    #1;
    check("f3_accept", 64'(bus.issue_accept_o), 64'd0);
    check("f3_ready", 64'(bus.issue_ready_o), 64'd1);
    step();
    check("f3_count", 64'(bus.count_o), 64'd0);

    // Reset with three queued entries
    bus.issue_instr_i = enc_sw(5'd7, 5'd2, 12'd0);
    for (int i = 0; i < 3; i++) begin
      bus.issue_id_i = 4'(i);
      step();
    end
    bus.issue_valid_i = 1'b0;
    check("pre_rst_count", 64'(bus.count_o), 64'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_count", 64'(bus.count_o), 64'd0);
    check("mid_rst_exv", 64'(bus.ex_valid_o), 64'd0);
    step();
    rst_ni = 1'b1;
    commit(1'b1, 4'd1, 1'b0);
    bus.ex_ready_i = 1'b1;
    step();
    commit(1'b0, 4'd0, 1'b0);
    #1;
    check("stale_commit_count", 64'(bus.count_o), 64'd0);
    check("stale_commit_exv", 64'(bus.ex_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
